// File: rtl/keystone_frame_sequencer_if.sv
// Stream handshake bundle between the sequencer and its input/output stream neighbours.
interface keystone_frame_sequencer_if;
  logic valid;
  logic start_of_frame;
  logic end_of_line;
  logic ready;
  logic out_ready;
  logic out_valid;
  logic out_sof;
  logic out_eol;

  modport master (
    output valid, start_of_frame, end_of_line, out_ready,
    input  ready, out_valid, out_sof, out_eol
  );

  modport slave (
    input  valid, start_of_frame, end_of_line, out_ready,
    output ready, out_valid, out_sof, out_eol
  );
endinterface

// File: rtl/keystone_frame_sequencer.sv
// Raster tracker for the keystone datapath pair: issues centred coordinates, latches
// the H matrix per frame and delays stream framing to match datapath latency.
module keystone_frame_sequencer #(
  parameter int WIDTH    = 1920,
  parameter int HEIGHT   = 1080,
  parameter int PIPE_LAT = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clock_en,
  input  logic [31:0][7:0]         m_map_registers,
  input  logic                     h_update,
  keystone_frame_sequencer_if.slave strm,
  output logic [31:0][7:0]         h_latched,
  output logic signed [31:0]       x_calc0,
  output logic signed [31:0]       x_calc1,
  output logic signed [31:0]       y_calc,
  output logic                     coord_valid,
  output logic [7:0]               status_and_debug
);

  localparam int CW     = $clog2(WIDTH + 1);
  localparam int RW     = $clog2(HEIGHT + 1);
  localparam int HALF_W = WIDTH / 2;
  localparam int HALF_H = HEIGHT / 2;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_next;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] col_cur;
  logic [RW-1:0] row_cur;
  logic          accept;
  logic          sof;
  logic          processed;
  logic          at_last_col;
  logic          line_end;
  logic          frame_end;
  logic          eol_bad;
  logic          sof_bad;
  logic [2:0]    dly_in;
  logic [2:0]    dly [0:PIPE_LAT];
  logic          sof_err;
  logic          eol_err;
  logic          dropped;
  logic          h_pending;
  logic          frame_done;

  assign strm.ready     = clock_en & strm.out_ready;
  assign strm.out_valid = dly[PIPE_LAT][2];
  assign strm.out_sof   = dly[PIPE_LAT][1];
  assign strm.out_eol   = dly[PIPE_LAT][0];
  assign status_and_debug = {2'b00, frame_done, (state == ACTIVE), h_pending,
                             dropped, eol_err, sof_err};

  // Beat classification, raster position of the current beat and next FSM state.
  always_comb begin
    accept      = strm.valid & strm.ready;
    sof         = accept & strm.start_of_frame;
    processed   = sof | (accept & (state == ACTIVE));
    // A start-of-frame beat is always treated as pixel pair (0,0), resyncing the raster.
    col_cur     = sof ? CW'(0) : col;
    row_cur     = sof ? RW'(0) : row;
    at_last_col = (col_cur == CW'(WIDTH - 2));
    line_end    = processed & (at_last_col | strm.end_of_line);
    eol_bad     = processed & (at_last_col ^ strm.end_of_line);
    frame_end   = line_end & (row_cur == RW'(HEIGHT - 1));
    sof_bad     = sof & (state == ACTIVE) & ((col != CW'(0)) | (row != RW'(0)));
    dly_in      = processed ? {1'b1, sof, line_end} : 3'b000;
    case (state)
      IDLE:    state_next = (processed & ~frame_end) ? ACTIVE : IDLE;
      ACTIVE:  state_next = frame_end ? IDLE : ACTIVE;
      default: state_next = IDLE;
    endcase
  end

  // Raster counters, coordinate issue, sticky status and H latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      col         <= CW'(0);
      row         <= RW'(0);
      x_calc0     <= 32'sd0;
      x_calc1     <= 32'sd0;
      y_calc      <= 32'sd0;
      coord_valid <= 1'b0;
      frame_done  <= 1'b0;
      sof_err     <= 1'b0;
      eol_err     <= 1'b0;
      dropped     <= 1'b0;
      h_pending   <= 1'b0;
      h_latched   <= 256'd0;
    end else begin
      coord_valid <= processed;
      frame_done  <= frame_end;
      sof_err     <= sof_err | sof_bad;
      eol_err     <= eol_err | eol_bad;
      dropped     <= dropped | (accept & ~processed);
      if (processed) begin
        state   <= state_next;
        x_calc0 <= int'(col_cur) - HALF_W;
        x_calc1 <= int'(col_cur) + 32'sd1 - HALF_W;
        y_calc  <= int'(row_cur) - HALF_H;
        if (frame_end) begin
          col <= CW'(0);
          row <= RW'(0);
        end else if (line_end) begin
          col <= CW'(0);
          row <= row_cur + RW'(1);
        end else begin
          col <= col_cur + CW'(2);
          row <= row_cur;
        end
      end
      if (sof & (h_pending | h_update)) begin
        h_latched <= m_map_registers;
        h_pending <= 1'b0;
      end else if (clock_en & h_update) begin
        h_pending <= 1'b1;
      end
    end
  end

  // Framing delay line: one issue stage plus PIPE_LAT datapath stages, stalled with the stream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= PIPE_LAT; i++) dly[i] <= 3'b000;
    end else if (strm.ready) begin
      dly[0] <= dly_in;
      for (int i = 1; i <= PIPE_LAT; i++) dly[i] <= dly[i-1];
    end
  end

endmodule

// File: doc/keystone_frame_sequencer.md
Name: keystone_frame_sequencer

Overview:
- Controller for the keystone correction datapath pair.
- Accepts the incoming two-pixel-per-beat video stream handshake and tracks the frame raster position.
- Issues centred (x0, x1, y) coordinates to datapath instances 0 and 1, and latches a frame-consistent copy of the H matrix from the memory-mapped registers at start of frame.
- Delays the stream framing flags by the datapath latency so the output stream stays aligned. Sits between the input stream interface, the two transformation datapaths and the output stream assembly.

Parameters:
- WIDTH, 1920, active pixels per line; must be even and at least 4.
- HEIGHT, 1080, active lines per frame; at least 2.
- PIPE_LAT, 8, datapath latency in accepted beats, from coordinate issue to colour available; at least 1.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- clock_en  input  1  global advance enable; when 0, all state holds.
- m_map_registers  input  32 x [7:0]  live H matrix coefficients a..h (index 0 = a), written by the processor.
- h_update  input  1  one-cycle pulse: processor finished writing m_map_registers.
- valid  input  1  input stream beat valid.
- start_of_frame  input  1  beat is first of frame (AXI tuser).
- end_of_line  input  1  beat is last of line (AXI tlast).
- ready  output  1  input stream ready.
- out_ready  input  1  downstream output stream ready.
- h_latched  output  32 x [7:0]  frame-stable H matrix fed to both datapaths.
- x_calc0, x_calc1, y_calc  output  int (32 signed)  centred coordinates for datapath 0, datapath 1 and the shared row.
- coord_valid  output  1  coordinates valid this cycle.
- out_valid, out_sof, out_eol  output  1 each  output stream framing, delayed PIPE_LAT beats.
- status_and_debug  output  8  bit0 sof_error, bit1 eol_error, bit2 dropped_beat, bit3 h_pending, bit4 in_frame, bit5 frame_done pulse, bits7:6 0.

Behaviour:
Reset values:
- All outputs 0, state IDLE, col = row = 0, h_latched all 0, delay line empty.

Handshake:
- ready = clock_en & out_ready; the whole pipeline stalls together.
- A beat is accepted when valid & ready.
- When not accepting, coord_valid = 0 next cycle and the delay line holds.

H latch:
- h_update sets h_pending.
- On an accepted beat with start_of_frame = 1, if h_pending (or h_update in the same cycle): h_latched <= m_map_registers and h_pending clears.
- h_latched never changes mid-frame.

FSM:
- IDLE: accepted beats without start_of_frame are discarded (ready still high), and dropped_beat is set sticky. An accepted beat with start_of_frame moves to ACTIVE and is processed as pixel pair (0,0).
- ACTIVE: each accepted beat issues coordinates for the current (col, row), then col += 2.
  - Line end occurs when col == WIDTH-2 or end_of_line = 1. At line end: col <= 0 and row += 1.
  - end_of_line with col != WIDTH-2 sets eol_error sticky and wraps early.
  - col == WIDTH-2 without end_of_line sets eol_error and wraps anyway.
  - Line end on row HEIGHT-1: frame_done pulses for 1 cycle, state goes to IDLE, row <= 0.
  - start_of_frame while ACTIVE at a position other than (0,0): sof_error sticky. Counters resync, and the beat is treated as pixel pair (0,0) with the H latch rule applied.
- Sticky error bits clear only on reset.
- in_frame = (state == ACTIVE).

Coordinates (registered, 1 cycle after acceptance, coord_valid = 1):
- x_calc0 = col - WIDTH/2
- x_calc1 = col + 1 - WIDTH/2
- y_calc = row - HEIGHT/2
- All values are sign-extended 32-bit.

Delay line:
- PIPE_LAT-stage shift of {valid, sof, eol}, advancing only on cycles where the upstream stream is ready.
- Entry: {1, start_of_frame-as-processed, line_end}; discarded beats enter as {0, 0, 0}.
- out_valid/out_sof/out_eol are the final stage.

Reset mid-operation: immediate return to the reset values, including the delay line being flushed.

Test Plan (WIDTH=8, HEIGHT=4, PIPE_LAT=3):
1. Reset, h_update pulse with a..h = 1..8, then a 16-beat frame with SOF on beat 0 and EOL on every 4th beat. Required: h_latched = 1..8 after beat 0; first coordinates (-4,-3,-2), beat 3 gives (2,3,-2), beat 4 gives (-4,-3,-1); frame_done pulses after beat 15; state returns to IDLE; out_valid trails coord_valid by 3 beats with out_eol on beats 3, 7, 11, 15.
2. 2 beats without SOF, then a frame. Required: dropped_beat = 1; no coord_valid for the 2 beats; the frame proceeds normally.
3. EOL on beat 1 of a line. Required: eol_error = 1; next beat gives (-4,-3,-1).
4. SOF on beat 6 of a frame. Required: sof_error = 1; that beat gives (-4,-3,-2).
5. out_ready low for 5 cycles mid-line. Required: ready = 0, coordinates and delay line frozen; resumes with no skipped or duplicated coordinates.
6. h_update mid-frame with new values. Required: h_latched unchanged until the next SOF, then updated; h_pending reads 1 in between.
